// File: rtl/button_conditioner.sv
// Per-button 2-FF synchroniser, debounce FSM and press-edge detector with a lowest-index one-hot press vector.
// Optional auto-repeat of held buttons is compiled in when BTN_AUTOREPEAT_EN is defined.
module button_conditioner #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] btn_in,
  output logic [N-1:0] btn_level,
  output logic [N-1:0] btn_press,
  output logic [N-1:0] btn_onehot
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {STABLE0, CHK1, STABLE1, CHK0} state_t;

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("button_conditioner: invalid timing parameters");
  end

  logic [N-1:0] sync1_reg, sync2_reg;
  logic [N-1:0] level_reg, press_reg, onehot_reg;
  logic [N-1:0] level_next, press_next, onehot_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= btn_in;
      sync2_reg <= sync1_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_btn
      state_t          state_reg, state_next;
      logic [CW-1:0]   cnt_reg, cnt_next;
      logic            qualify;
      logic            s;

      assign s = sync2_reg[gi];

      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg <= STABLE0;
          cnt_reg   <= '0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
        end
      end

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        qualify    = 1'b0;
        case (state_reg)
          STABLE0: if (s) begin
            state_next = CHK1;
            cnt_next   = '0;
          end
          CHK1: begin
            if (!s) state_next = STABLE0;
            else if (cnt_reg == CNT_LAST) begin
              state_next = STABLE1;
              qualify    = 1'b1;
            end else cnt_next = cnt_reg + 1'b1;
          end
          STABLE1: if (!s) begin
            state_next = CHK0;
            cnt_next   = '0;
          end
          CHK0: begin
            if (s) state_next = STABLE1;
            else if (cnt_reg == CNT_LAST) state_next = STABLE0;
            else cnt_next = cnt_reg + 1'b1;
          end
          default: state_next = STABLE0;
        endcase
      end

      // Level is high in STABLE1 and while a release is still being confirmed.
      assign level_next[gi] = (state_next == STABLE1) || (state_next == CHK0);

`ifdef BTN_AUTOREPEAT_EN
      localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
      localparam int RW   = $clog2(RMAX + 1);
      localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
      localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

      logic [RW-1:0] rpt_cnt_reg, rpt_cnt_next;
      logic          rpt_first_reg, rpt_first_next;
      logic          rpt_fire;
      logic          holding;

      assign holding = (state_reg == STABLE1) && (state_next == STABLE1);

      always_ff @(posedge clk) begin
        if (rst) begin
          rpt_cnt_reg   <= '0;
          rpt_first_reg <= 1'b1;
        end else begin
          rpt_cnt_reg   <= rpt_cnt_next;
          rpt_first_reg <= rpt_first_next;
        end
      end

      // First repeat waits the long delay, later ones use the period.
      always_comb begin
        rpt_cnt_next   = rpt_cnt_reg;
        rpt_first_next = rpt_first_reg;
        rpt_fire       = 1'b0;
        if (holding) begin
          if (rpt_cnt_reg == (rpt_first_reg ? DLY_LAST : PER_LAST)) begin
            rpt_fire       = 1'b1;
            rpt_cnt_next   = '0;
            rpt_first_next = 1'b0;
          end else begin
            rpt_cnt_next = rpt_cnt_reg + 1'b1;
          end
        end else begin
          rpt_cnt_next   = '0;
          rpt_first_next = 1'b1;
        end
      end

      assign press_next[gi] = qualify | rpt_fire;
`else
      assign press_next[gi] = qualify;
`endif
    end
  endgenerate

  // Isolate the lowest set bit so onehot stays aligned with press.
  assign onehot_next = press_next & (~press_next + 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      level_reg  <= '0;
      press_reg  <= '0;
      onehot_reg <= '0;
    end else begin
      level_reg  <= level_next;
      press_reg  <= press_next;
      onehot_reg <= onehot_next;
    end
  end

  assign btn_level  = level_reg;
  assign btn_press  = press_reg;
  assign btn_onehot = onehot_reg;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed self-checking bench for button_conditioner: table-driven presses plus bounce, glitch,
// release, reset and auto-repeat sequences.
module tb_button_conditioner;
  localparam int N   = 4;
  localparam int DB  = 8;
  localparam int RD  = 20;
  localparam int RP  = 5;
  localparam int LAT = DB + 3;

`ifdef BTN_AUTOREPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn_in;
  logic [N-1:0] btn_level, btn_press, btn_onehot;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [3:0] btn;
    logic [3:0] exp_press;
    logic [3:0] exp_onehot;
  } vec_t;

  vec_t tbl[6];

  always #5 clk = ~clk;

  button_conditioner #(
    .N(N), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .btn_level(btn_level), .btn_press(btn_press), .btn_onehot(btn_onehot)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end else begin
      $display("ok   %s: %b", name, got);
    end
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    btn_in = '0;
    repeat (3) step();
    check("reset level", btn_level, 4'b0000);
    check("reset press", btn_press, 4'b0000);
    check("reset onehot", btn_onehot, 4'b0000);
    rst = 1'b0;
  endtask

  function automatic logic [3:0] rep_exp(input int k, input logic [3:0] b);
    if (REP_EN && k >= RD && ((k - RD) % RP) == 0) return b;
    return 4'b0000;
  endfunction

  initial begin
    rst    = 1'b1;
    btn_in = '0;
    tbl[0] = '{4'b0001, 4'b0001, 4'b0001};
    tbl[1] = '{4'b1010, 4'b1010, 4'b0010};
    tbl[2] = '{4'b0110, 4'b0110, 4'b0010};
    tbl[3] = '{4'b1111, 4'b1111, 4'b0001};
    tbl[4] = '{4'b0100, 4'b0100, 4'b0100};
    tbl[5] = '{4'b1000, 4'b1000, 4'b1000};

    // Table: clean and simultaneous presses, each from a fresh reset.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      btn_in = tbl[i].btn;
      for (int k = 1; k < LAT; k++) begin
        step();
        check($sformatf("tbl%0d pre-press k%0d", i, k), btn_press, 4'b0000);
      end
      step();
      check($sformatf("tbl%0d press", i), btn_press, tbl[i].exp_press);
      check($sformatf("tbl%0d onehot", i), btn_onehot, tbl[i].exp_onehot);
      check($sformatf("tbl%0d level", i), btn_level, tbl[i].btn);
      for (int k = 1; k <= 15; k++) begin
        step();
        check($sformatf("tbl%0d hold press k%0d", i, k), btn_press, 4'b0000);
      end
      check($sformatf("tbl%0d hold level", i), btn_level, tbl[i].btn);
    end

    // Bounce on button 1: 3-cycle toggles never qualify, final rise does.
    do_reset();
    for (int c = 0; c < 30; c++) begin
      btn_in[1] = ((c / 3) % 2) == 0;
      step();
      check($sformatf("bounce c%0d press", c), btn_press, 4'b0000);
    end
    check("bounce level", btn_level, 4'b0000);
    btn_in[1] = 1'b1;
    for (int k = 1; k < LAT; k++) begin
      step();
      check($sformatf("bounce settle k%0d", k), btn_press, 4'b0000);
    end
    step();
    check("bounce press", btn_press, 4'b0010);
    check("bounce onehot", btn_onehot, 4'b0010);
    step();
    check("bounce single pulse", btn_press, 4'b0000);
    check("bounce level held", btn_level, 4'b0010);

    // Button 2: press, 5-cycle low glitch, then real release.
    do_reset();
    btn_in = 4'b0100;
    repeat (LAT) step();
    check("rel press", btn_press, 4'b0100);
    btn_in = 4'b0000;
    repeat (5) step();
    btn_in = 4'b0100;
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("glitch k%0d level", k), btn_level, 4'b0100);
      check($sformatf("glitch k%0d press", k), btn_press, 4'b0000);
    end
    btn_in = 4'b0000;
    for (int k = 1; k < LAT; k++) begin
      step();
      check($sformatf("release k%0d level", k), btn_level, 4'b0100);
      check($sformatf("release k%0d press", k), btn_press, 4'b0000);
    end
    step();
    check("release level fall", btn_level, 4'b0000);
    check("release no pulse", btn_press, 4'b0000);

    // Reset while button 3 sits at cnt=5 of CHK1.
    do_reset();
    btn_in = 4'b1000;
    repeat (8) step();
    check("mid level before rst", btn_level, 4'b0000);
    rst = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      check($sformatf("mid rst k%0d level", k), btn_level, 4'b0000);
      check($sformatf("mid rst k%0d press", k), btn_press, 4'b0000);
      check($sformatf("mid rst k%0d onehot", k), btn_onehot, 4'b0000);
    end
    rst = 1'b0;
    for (int k = 1; k < LAT; k++) begin
      step();
      check($sformatf("mid requal k%0d", k), btn_press, 4'b0000);
    end
    step();
    check("mid requal press", btn_press, 4'b1000);
    check("mid requal onehot", btn_onehot, 4'b1000);
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("mid after k%0d", k), btn_press, 4'b0000);
    end

    // Long hold on button 0: repeats only when the feature is compiled in.
    do_reset();
    btn_in = 4'b0001;
    repeat (LAT) step();
    check("rpt initial press", btn_press, 4'b0001);
    for (int k = 1; k <= 60; k++) begin
      step();
      check($sformatf("rpt k%0d press", k), btn_press, rep_exp(k, 4'b0001));
      check($sformatf("rpt k%0d onehot", k), btn_onehot, rep_exp(k, 4'b0001));
    end
    btn_in = 4'b0000;
    for (int k = 1; k <= 15; k++) begin
      step();
      check($sformatf("rpt release k%0d", k), btn_press, 4'b0000);
    end
    check("rpt release level", btn_level, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
